// File: rtl/micro_pkg.sv
// Shared micro-state encodings, dispatch codes and mask defaults for the micro-sequencer.
// Pure declarations: no latency, no backpressure.
package micro_pkg;

  typedef logic [3:0] ustate_t;

  localparam ustate_t FETCH    = 4'd0;
  localparam ustate_t DECODE   = 4'd1;
  localparam ustate_t MEMADR   = 4'd2;
  localparam ustate_t MEMREAD  = 4'd3;
  localparam ustate_t MEMWRITE = 4'd4;
  localparam ustate_t MEMWB    = 4'd5;
  localparam ustate_t EXECR    = 4'd6;
  localparam ustate_t EXECI    = 4'd7;
  localparam ustate_t ALUWB    = 4'd8;
  localparam ustate_t BRANCH   = 4'd9;

  localparam logic [3:0] DISP1 = 4'hF;
  localparam logic [3:0] DISP2 = 4'hE;

  // NextPC, RegW, MemW, IRWrite, Branch
  localparam logic [15:0] WE_MASK_DEFAULT = 16'hF400;

  // States that touch memory and can therefore be held by memReady.
  function automatic logic is_mem_state(input ustate_t s);
    return (s == FETCH) || (s == MEMREAD) || (s == MEMWRITE);
  endfunction

  // Final micro-state of each legal instruction class.
  function automatic logic is_retire_state(input ustate_t s);
    return (s == MEMWRITE) || (s == MEMWB) || (s == ALUWB) || (s == BRANCH);
  endfunction

endpackage

// File: rtl/micro_dispatch.sv
// Next micro-address decode from the NEXT field, op and funct; purely combinational, zero latency.
// No backpressure: the caller decides whether the result is taken.
module micro_dispatch
  import micro_pkg::*;
(
  input  logic [3:0] nextField,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  output ustate_t    nextAdr,
  output logic       illegalHit
);

  // Only the I and L bits steer dispatch; the rest belongs to the datapath.
  logic unused_funct;
  assign unused_funct = ^funct[4:1];

  always_comb begin
    nextAdr    = FETCH;
    illegalHit = 1'b0;
    if (nextField == DISP1) begin
      unique case (op)
        2'b00:   nextAdr = funct[5] ? EXECI : EXECR;
        2'b01:   nextAdr = MEMADR;
        2'b10:   nextAdr = BRANCH;
        default: illegalHit = 1'b1;
      endcase
    end else if (nextField == DISP2) begin
      nextAdr = funct[0] ? MEMREAD : MEMWRITE;
    end else if (nextField <= BRANCH) begin
      nextAdr = nextField;
    end else begin
      illegalHit = 1'b1;
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// Micro-PC register with dispatch, stall masking, sticky illegal flag and retire counter; adr updates 1 cycle after NEXT.
// Backpressure: memReady low in Fetch/MemRead/MemWrite holds adr and the counter and masks write enables in ctrl.
module micro_sequencer
  import micro_pkg::*;
#(
  parameter logic [15:0] WE_MASK = WE_MASK_DEFAULT,
  parameter int          CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       op,
  input  logic [5:0]       funct,
  input  logic             memReady,
  input  logic [15:0]      controlWord,
  output ustate_t          adr,
  output logic [15:0]      ctrl,
  output logic             stall,
  output logic             illegal,
  output logic [CNT_W-1:0] instrCount
);

  ustate_t disp_adr;
  logic    disp_illegal;

  micro_dispatch u_dispatch (
    .nextField  (controlWord[3:0]),
    .op         (op),
    .funct      (funct),
    .nextAdr    (disp_adr),
    .illegalHit (disp_illegal)
  );

  assign stall = ~memReady & is_mem_state(adr);
  assign ctrl  = stall ? (controlWord & ~WE_MASK) : controlWord;

  always_ff @(posedge clk) begin
    if (reset) begin
      adr        <= FETCH;
      illegal    <= 1'b0;
      instrCount <= '0;
    end else if (!stall) begin
      adr <= disp_adr;
      if (disp_illegal)
        illegal <= 1'b1;
      // A return to Fetch caused by an illegal encoding is not a retirement.
      if (is_retire_state(adr) && (disp_adr == FETCH) && !disp_illegal)
        instrCount <= instrCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench: instruction-level reference (expected micro-state paths per class) against the sequencer.
// Random memReady stalls and random instruction streams; narrow counter so wrap is reached.
module tb_micro_sequencer;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       op;
  logic [5:0]       funct;
  logic             memReady;
  logic [15:0]      controlWord;
  logic [3:0]       adr;
  logic [15:0]      ctrl;
  logic             stall;
  logic             illegal;
  logic [CNT_W-1:0] instrCount;

  typedef struct packed {
    logic [3:0]       adr;
    logic             stall;
    logic [15:0]      ctrl;
    logic             ill;
    logic [CNT_W-1:0] cnt;
  } obs_t;

  int checks = 0;
  int errors = 0;

  logic [15:0]      rom [16];
  logic [CNT_W-1:0] exp_cnt;
  logic             exp_ill;
  logic [3:0]       path [$];
  logic [1:0]       plan_op;
  logic [5:0]       plan_funct;
  bit               plan_retire;
  bit               plan_illegal;
  obs_t             got_q [$];
  obs_t             exp_q [$];

  micro_sequencer #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .funct       (funct),
    .memReady    (memReady),
    .controlWord (controlWord),
    .adr         (adr),
    .ctrl        (ctrl),
    .stall       (stall),
    .illegal     (illegal),
    .instrCount  (instrCount)
  );

  always #5 clk = ~clk;

  // Combinational control store addressed by the micro-PC.
  assign controlWord = rom[adr];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] rom_next(input int i);
    case (i)
      0:       return 4'd1;
      1:       return 4'hF;
      2:       return 4'hE;
      3:       return 4'd5;
      6, 7:    return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  task automatic load_rom();
    logic [31:0] r;
    for (int i = 0; i < 16; i++) begin
      r = $urandom();
      rom[i] = {r[15:4], rom_next(i)};
      if (i == 0 || i == 3 || i == 4)
        rom[i] = rom[i] | 16'hF400;
    end
  endtask

  // Expected micro-state path of one instruction, from the instruction class alone.
  task automatic plan_instr(input logic [1:0] o, input logic [5:0] f);
    path.delete();
    plan_op      = o;
    plan_funct   = f;
    plan_retire  = 1'b1;
    plan_illegal = 1'b0;
    path.push_back(4'd0);
    path.push_back(4'd1);
    case (o)
      2'b00: begin
        path.push_back(f[5] ? 4'd7 : 4'd6);
        path.push_back(4'd8);
      end
      2'b01: begin
        path.push_back(4'd2);
        if (f[0]) begin
          path.push_back(4'd3);
          path.push_back(4'd5);
        end else begin
          path.push_back(4'd4);
        end
      end
      2'b10: path.push_back(4'd9);
      default: begin
        plan_retire  = 1'b0;
        plan_illegal = 1'b1;
      end
    endcase
  endtask

  // Walks the planned path cycle by cycle, recording observed and expected outputs.
  task automatic run_plan(input logic [3:0] hold_state, input int hold_n, input int pct);
    foreach (path[i]) begin
      int held;
      bit es;
      held = 0;
      forever begin
        @(negedge clk);
        if (i == 0) begin
          op    = plan_op;
          funct = plan_funct;
        end
        if (path[i] == hold_state && held < hold_n) memReady = 1'b0;
        else if (held >= 6)                         memReady = 1'b1;
        else                                        memReady = ($urandom_range(99) >= pct);
        #1;
        es = !memReady && (path[i] == 4'd0 || path[i] == 4'd3 || path[i] == 4'd4);
        got_q.push_back({adr, stall, ctrl, illegal, instrCount});
        exp_q.push_back({path[i], es, es ? (rom[path[i]] & 16'h0BFF) : rom[path[i]], exp_ill, exp_cnt});
        if (!es) break;
        held++;
      end
    end
    if (plan_retire)  exp_cnt = exp_cnt + 1'b1;
    if (plan_illegal) exp_ill = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; memReady = 1'b1; op = 2'b00; funct = 6'd0;
    exp_cnt = '0; exp_ill = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (adr !== 4'd0 || illegal !== 1'b0 || instrCount !== '0) begin
      errors++;
      $display("FAIL reset_first_edge: got adr=%0d illegal=%0b cnt=%0d, expected 0/0/0", adr, illegal, instrCount);
    end
    @(posedge clk); #1;
    checks++;
    if (adr !== 4'd0 || illegal !== 1'b0 || instrCount !== '0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: got adr=%0d illegal=%0b cnt=%0d stall=%0b, expected 0/0/0/0", adr, illegal, instrCount, stall);
    end
    reset = 1'b0;
  endtask

  task automatic test_dp();
    got_q.delete(); exp_q.delete();
    plan_instr(2'b00, 6'b001000);
    run_plan(4'hF, 0, 0);
    foreach (got_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL dp cycle %0d: got {adr,stall,ctrl,ill,cnt}=%h expected %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_ldr_stall();
    got_q.delete(); exp_q.delete();
    plan_instr(2'b01, 6'b011001);
    run_plan(4'd3, 2, 0);
    foreach (got_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL ldr_stall cycle %0d: got {adr,stall,ctrl,ill,cnt}=%h expected %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_str_b();
    got_q.delete(); exp_q.delete();
    plan_instr(2'b01, 6'b011000);
    run_plan(4'hF, 0, 0);
    plan_instr(2'b10, 6'($urandom_range(63)));
    run_plan(4'hF, 0, 0);
    foreach (got_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL str_b cycle %0d: got {adr,stall,ctrl,ill,cnt}=%h expected %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_illegal();
    got_q.delete(); exp_q.delete();
    plan_instr(2'b11, 6'($urandom_range(63)));
    run_plan(4'hF, 0, 0);
    plan_instr(2'b00, 6'b001000);
    run_plan(4'hF, 0, 0);
    foreach (got_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL illegal cycle %0d: got {adr,stall,ctrl,ill,cnt}=%h expected %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    guard = 0;
    @(negedge clk);
    op = 2'b01; funct = 6'b000001; memReady = 1'b1;
    #1;
    while (adr !== 4'd5 && guard < 20) begin
      @(negedge clk); #1;
      guard++;
    end
    checks++;
    if (adr !== 4'd5) begin
      errors++;
      $display("FAIL reset_mid_reach: got adr=%0d, expected 5 within 20 cycles", adr);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_cnt = '0; exp_ill = 1'b0;
    checks++;
    if (adr !== 4'd0 || instrCount !== '0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got adr=%0d cnt=%0d illegal=%0b, expected 0/0/0", adr, instrCount, illegal);
    end
  endtask

  task automatic test_invalid_next();
    logic [15:0] saved;
    got_q.delete(); exp_q.delete();
    saved = rom[6];
    rom[6] = {saved[15:4], 4'hC};
    plan_instr(2'b00, 6'b000100);
    void'(path.pop_back());
    plan_retire  = 1'b0;
    plan_illegal = 1'b1;
    run_plan(4'hF, 0, 0);
    @(posedge clk); #1;
    rom[6] = saved;
    plan_instr(2'b00, 6'b001000);
    run_plan(4'hF, 0, 20);
    foreach (got_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL invalid_next cycle %0d: got {adr,stall,ctrl,ill,cnt}=%h expected %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    int r;
    got_q.delete(); exp_q.delete();
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(7);
      plan_instr((r == 0) ? 2'b11 : 2'(r % 3), 6'($urandom_range(63)));
      run_plan(4'hF, 0, 30);
    end
    foreach (got_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL random cycle %0d: got {adr,stall,ctrl,ill,cnt}=%h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    @(negedge clk); #1;
    checks++;
    if (instrCount !== exp_cnt || illegal !== exp_ill) begin
      errors++;
      $display("FAIL random_final: got cnt=%0d illegal=%0b, expected %0d/%0b", instrCount, illegal, exp_cnt, exp_ill);
    end
  endtask

  initial begin
    load_rom();
    test_reset();
    test_dp();
    test_ldr_stall();
    test_str_b();
    test_illegal();
    test_reset_mid();
    test_invalid_next();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
